// File: rtl/kernel_window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kernel_window_pkg
// Description : Shared types and default sizes for the median-filter window
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package kernel_window_pkg;

  localparam int K_DEFAULT        = 5;
  localparam int ADDR_W_DEFAULT   = 11;
  localparam int ROW_W_DEFAULT    = 11;
  localparam int PIPE_LAT_DEFAULT = 2;

  // Distance from the window edge to its centre for the default kernel
  localparam int HALF_K = (K_DEFAULT - 1) / 2;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    LINE0   = 2'd1,
    FILL    = 2'd2,
    RUN     = 2'd3
  } kw_state_t;

  // Centre offset for an arbitrary odd kernel size
  function automatic int half_k(input int k);
    return (k - 1) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kernel_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : kernel_window_ctrl_if
// Description : Receiver timing inputs and line-buffer / window control
//               outputs of the window sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface kernel_window_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int ROW_W  = 11
);

  logic              in_dv;
  logic              in_hs;
  logic              in_vs;
  logic              lb_we;
  logic [ADDR_W-1:0] lb_addr;
  logic              shr_en;
  logic              win_valid;
  logic [ADDR_W-1:0] ctr_x;
  logic [ROW_W-1:0]  ctr_y;
  logic [ADDR_W-1:0] line_width;
  logic              width_err;
  logic              out_hs;
  logic              out_vs;

  // Video source side: drives timing, observes control outputs
  modport master (
    output in_dv, in_hs, in_vs,
    input  lb_we, lb_addr, shr_en, win_valid, ctr_x, ctr_y,
    input  line_width, width_err, out_hs, out_vs
  );

  // Sequencer side
  modport slave (
    input  in_dv, in_hs, in_vs,
    output lb_we, lb_addr, shr_en, win_valid, ctr_x, ctr_y,
    output line_width, width_err, out_hs, out_vs
  );

endinterface
`default_nettype wire

// File: rtl/sig_delay.sv
`default_nettype none
// ============================================================================
// Module      : sig_delay
// Description : Fixed-depth register delay line with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift the sample one stage per clock; reset flushes every stage
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
          r_stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign dout = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/kernel_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kernel_window_ctrl
// Description : Line-buffer sequencer for a KxK median filter. Tracks frame
//               and line boundaries, measures the active width, drives the
//               shared BRAM address/write enable and produces the window
//               valid qualifier and centre coordinates aligned to the
//               shift-register datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_window_ctrl
  import kernel_window_pkg::*;
#(
  parameter int K        = K_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int ROW_W    = ROW_W_DEFAULT,
  parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  kernel_window_ctrl_if.slave bus
);

  localparam int                c_half      = half_k(K);
  localparam logic [ADDR_W-1:0] c_col_max   = '1;
  localparam logic [ROW_W-1:0]  c_row_max   = '1;
  localparam logic [ADDR_W-1:0] c_col_first = ADDR_W'(K - 1);
  localparam logic [ROW_W-1:0]  c_fill_last = ROW_W'(K - 2);
  localparam int                c_dly_w     = 4 + ADDR_W + ROW_W;

  kw_state_t         r_state;
  logic              r_dv;
  logic              r_vs;
  logic [ADDR_W-1:0] r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_line_width;
  logic              r_width_err;

  logic              w_dv_rise;
  logic              w_dv_fall;
  logic              w_vs_rise;
  logic              w_vs_fall;
  logic              w_active;
  logic [ADDR_W-1:0] w_col;
  logic              w_col_sat;
  logic [ADDR_W-1:0] w_col_next;
  logic              w_win;
  logic [ADDR_W-1:0] w_ctr_x;
  logic [ROW_W-1:0]  w_ctr_y;
  logic [c_dly_w-1:0] w_dly_in;
  logic [c_dly_w-1:0] w_dly_out;

  assign w_dv_rise = bus.in_dv & ~r_dv;
  assign w_dv_fall = ~bus.in_dv & r_dv;
  assign w_vs_rise = bus.in_vs & ~r_vs;
  assign w_vs_fall = ~bus.in_vs & r_vs;

  // A vsync rise abandons the frame in the same cycle; a vsync fall opens
  // the frame in the same cycle so a coincident first pixel is column 0.
  assign w_active = (r_state != WAIT_VS) ? ~w_vs_rise : w_vs_fall;

  // Column seen by this pixel: restarts on a new line or a new frame
  assign w_col      = (w_dv_rise | w_vs_fall) ? '0 : r_col;
  assign w_col_sat  = (w_col == c_col_max);
  assign w_col_next = w_col_sat ? w_col : w_col + ADDR_W'(1);

  // Window is complete once K-1 lines are buffered and K columns shifted in
  assign w_win   = bus.in_dv & w_active & (r_state == RUN) & (w_col >= c_col_first);
  assign w_ctr_x = w_win ? w_col - ADDR_W'(c_half) : '0;
  assign w_ctr_y = w_win ? r_row - ROW_W'(c_half) : '0;

  assign bus.lb_we      = bus.in_dv & w_active;
  assign bus.lb_addr    = w_col;
  assign bus.line_width = r_line_width;
  assign bus.width_err  = r_width_err;

  // Frame/line sequencer with column, row, width and error tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= WAIT_VS;
      r_dv         <= 1'b0;
      r_vs         <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_line_width <= '0;
      r_width_err  <= 1'b0;
    end else begin
      r_dv <= bus.in_dv;
      r_vs <= bus.in_vs;

      if (!w_active) begin
        r_col <= '0;
      end else if (bus.in_dv) begin
        r_col <= w_col_next;
      end

      if (w_vs_fall) r_width_err <= 1'b0;
      if (w_active && bus.in_dv && w_col_sat) r_width_err <= 1'b1;

      case (r_state)
        WAIT_VS: begin
          if (w_vs_fall) begin
            r_state <= LINE0;
            r_row   <= '0;
          end
        end
        LINE0: begin
          if (w_vs_rise) begin
            r_state <= WAIT_VS;
          end else if (w_dv_fall) begin
            r_line_width <= r_col;
            r_row        <= ROW_W'(1);
            r_state      <= FILL;
          end
        end
        FILL, RUN: begin
          if (w_vs_rise) begin
            r_state <= WAIT_VS;
          end else if (w_dv_fall) begin
            if (r_col != r_line_width) r_width_err <= 1'b1;
            if (r_row != c_row_max) r_row <= r_row + ROW_W'(1);
            if (r_state == FILL && r_row == c_fill_last) r_state <= RUN;
          end
        end
        default: r_state <= WAIT_VS;
      endcase
    end
  end

  assign w_dly_in = {bus.in_dv, w_win, bus.in_hs, bus.in_vs, w_ctr_x, w_ctr_y};

  sig_delay #(
    .WIDTH (c_dly_w),
    .DEPTH (PIPE_LAT)
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .din  (w_dly_in),
    .dout (w_dly_out)
  );

  assign bus.shr_en    = w_dly_out[c_dly_w-1];
  assign bus.win_valid = w_dly_out[c_dly_w-2];
  assign bus.out_hs    = w_dly_out[c_dly_w-3];
  assign bus.out_vs    = w_dly_out[c_dly_w-4];
  assign bus.ctr_x     = w_dly_out[ADDR_W+ROW_W-1:ROW_W];
  assign bus.ctr_y     = w_dly_out[ROW_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_kernel_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_window_ctrl
// Description : Self-checking bench for kernel_window_ctrl. A frame-level
//               reference (line index, column, measured width) predicts
//               every output; a second instance with a 3-bit address checks
//               column saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_window_ctrl;

  localparam int c_k      = 5;
  localparam int c_half   = 2;
  localparam int c_lat    = 2;
  localparam int c_s_max  = 7;

  typedef struct packed {
    logic        shr;
    logic        win;
    logic        hs;
    logic        vs;
    logic [10:0] x;
    logic [10:0] y;
  } dly_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dv  = 1'b0;
  logic hs  = 1'b0;
  logic vs  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  bit   m_live   = 0;
  bit   m_prev_vs = 0;
  int   m_line   = 0;
  int   m_width  = 0;
  bit   m_err    = 0;
  bit   m_ovf    = 0;
  int   m_vcount = 0;
  dly_t m_q[$];

  always #5 clk = ~clk;

  kernel_window_ctrl_if #(.ADDR_W(11), .ROW_W(11)) bus ();
  kernel_window_ctrl_if #(.ADDR_W(3),  .ROW_W(11)) bus_s ();

  assign bus.in_dv   = dv;
  assign bus.in_hs   = hs;
  assign bus.in_vs   = vs;
  assign bus_s.in_dv = dv;
  assign bus_s.in_hs = hs;
  assign bus_s.in_vs = vs;

  kernel_window_ctrl #(.K(5), .ADDR_W(11), .ROW_W(11), .PIPE_LAT(c_lat)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  kernel_window_ctrl #(.K(5), .ADDR_W(3), .ROW_W(11), .PIPE_LAT(c_lat)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; col is the pixel index within the line
  task automatic tick(input logic dv_i, input logic hs_i, input logic vs_i, input int col);
    dly_t now;
    dly_t exp;
    bit   we;
    @(posedge clk);
    #1;
    if (rst) begin
      m_live    = 0;
      m_prev_vs = 0;
      m_line    = 0;
      m_width   = 0;
      m_err     = 0;
      m_ovf     = 0;
      m_q       = {};
      for (int i = 0; i < c_lat; i++) m_q.push_back('0);
    end
    rst = 1'b0;
    dv  = dv_i;
    hs  = hs_i;
    vs  = vs_i;
    if (m_prev_vs && !vs_i) begin
      m_live   = 1;
      m_line   = 0;
      m_err    = 0;
      m_ovf    = 0;
      m_vcount = 0;
    end
    if (!m_prev_vs && vs_i) m_live = 0;
    m_prev_vs = vs_i;
    we = dv_i && m_live;
    if (we && col >= c_s_max) m_ovf = 1;
    now     = '0;
    now.shr = dv_i;
    now.hs  = hs_i;
    now.vs  = vs_i;
    now.win = we && (m_line >= c_k - 1) && (col >= c_k - 1);
    if (now.win) begin
      now.x = 11'(col - c_half);
      now.y = 11'(m_line - c_half);
    end
    m_q.push_back(now);
    exp = m_q.pop_front();
    @(negedge clk);
    check_eq("lb_we", 32'(bus.lb_we), 32'(we));
    check_eq("lb_we_small", 32'(bus_s.lb_we), 32'(we));
    if (we) begin
      check_eq("lb_addr", 32'(bus.lb_addr), 32'(col));
      check_eq("lb_addr_small", 32'(bus_s.lb_addr), 32'((col > c_s_max) ? c_s_max : col));
    end
    check_eq("shr_en", 32'(bus.shr_en), 32'(exp.shr));
    check_eq("win_valid", 32'(bus.win_valid), 32'(exp.win));
    check_eq("out_hs", 32'(bus.out_hs), 32'(exp.hs));
    check_eq("out_vs", 32'(bus.out_vs), 32'(exp.vs));
    if (exp.win) begin
      check_eq("ctr_x", 32'(bus.ctr_x), 32'(exp.x));
      check_eq("ctr_y", 32'(bus.ctr_y), 32'(exp.y));
    end
    if (bus.win_valid) m_vcount++;
  endtask

  // Active line of w pixels; abort_col >= 0 raises vsync on that pixel
  task automatic send_line(input int w, input int abort_col, input int blank);
    bit aborted = 0;
    for (int c = 0; c < w; c++) begin
      if (c == abort_col) begin
        tick(1'b1, 1'b0, 1'b1, c);
        aborted = 1;
        break;
      end
      tick(1'b1, 1'b0, 1'b0, c);
    end
    if (!aborted && m_live) begin
      if (m_line == 0) m_width = w;
      else if (w != m_width) m_err = 1;
      m_line++;
    end
    for (int b = 0; b < blank; b++) tick(1'b0, !aborted, aborted, 0);
    if (!aborted) begin
      check_eq("line_width", 32'(bus.line_width), 32'(m_width));
      check_eq("width_err", 32'(bus.width_err), 32'(m_err));
      check_eq("width_err_small", 32'(bus_s.width_err), 32'(m_err | m_ovf));
    end
  endtask

  // Vsync pulse; with merge the falling edge lands on the next line's first pixel
  task automatic vsync(input int hold, input bit merge);
    for (int i = 0; i < hold; i++) tick(1'b0, 1'b0, 1'b1, 0);
    if (!merge) tick(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic run_frame(input int w, input int n, input int bad_line, input int bad_w,
                           input bit merge, input int blank);
    int exp_valid = 0;
    int wl;
    vsync(3, merge);
    for (int l = 0; l < n; l++) begin
      wl = (l == bad_line) ? bad_w : w;
      send_line(wl, -1, blank);
      if (l >= c_k - 1 && wl > c_k - 1) exp_valid += wl - (c_k - 1);
    end
    check_eq("valid_count", 32'(m_vcount), 32'(exp_valid));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_lb_we"}, 32'(bus.lb_we), 32'd0);
    check_eq({tag, "_lb_addr"}, 32'(bus.lb_addr), 32'd0);
    check_eq({tag, "_shr_en"}, 32'(bus.shr_en), 32'd0);
    check_eq({tag, "_win_valid"}, 32'(bus.win_valid), 32'd0);
    check_eq({tag, "_ctr_x"}, 32'(bus.ctr_x), 32'd0);
    check_eq({tag, "_ctr_y"}, 32'(bus.ctr_y), 32'd0);
    check_eq({tag, "_line_width"}, 32'(bus.line_width), 32'd0);
    check_eq({tag, "_width_err"}, 32'(bus.width_err), 32'd0);
    check_eq({tag, "_out_hs"}, 32'(bus.out_hs), 32'd0);
    check_eq({tag, "_out_vs"}, 32'(bus.out_vs), 32'd0);
  endtask

  initial begin
    int w;
    int n;
    int bl;
    // Reset state
    tick(1'b0, 1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 1'b0, 0);
    check_all_zero("reset");

    // Pixels before any frame start must not write
    send_line(6, -1, 3);
    send_line(6, -1, 3);

    // Basic frame, then one with a short line 3
    run_frame(8, 6, -1, 0, 1'b0, 4);
    run_frame(8, 6, 3, 7, 1'b0, 4);

    // First pixel coincides with the vsync falling edge
    run_frame(8, 6, -1, 0, 1'b1, 4);

    // Vsync rises mid-line 5, then a clean frame restarts rows
    vsync(3, 1'b0);
    for (int l = 0; l < 5; l++) send_line(8, -1, 4);
    send_line(8, 3, 4);
    run_frame(8, 6, -1, 0, 1'b0, 4);

    // Reset during line 4 column 6
    vsync(3, 1'b0);
    for (int l = 0; l < 4; l++) send_line(8, -1, 4);
    for (int c = 0; c < 6; c++) tick(1'b1, 1'b0, 1'b0, c);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dv  = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 7);
    check_all_zero("post_rst");
    for (int b = 0; b < 3; b++) tick(1'b0, 1'b1, 1'b0, 0);
    send_line(8, -1, 4);
    run_frame(10, 6, -1, 0, 1'b0, 4);
    check_eq("ovf_err_small", 32'(bus_s.width_err), 32'd1);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      w  = $urandom_range(5, 12);
      n  = $urandom_range(5, 8);
      bl = $urandom_range(2, 6);
      run_frame(w, n, ($urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1,
                $urandom_range(3, 12), $urandom_range(0, 1) == 1, bl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
